// File: rtl/cart_type_detect_if.sv
// Load-stream and result bundle for the cartridge type detector.
// The testbench drives the master side; the detector is the slave.
interface cart_type_detect_if;
  logic [14:0] addr;
  logic        ena;
  logic        load_done;
  logic [4:0]  match_flags;
  logic [15:0] rom_size;
  logic [3:0]  cart_type;
  logic        sc;
  logic        type_valid;
  logic        busy;

  modport slave (
    input  addr,
    input  ena,
    input  load_done,
    input  match_flags,
    output rom_size,
    output cart_type,
    output sc,
    output type_valid,
    output busy
  );

  modport master (
    output addr,
    output ena,
    output load_done,
    output match_flags,
    input  rom_size,
    input  cart_type,
    input  sc,
    input  type_valid,
    input  busy
  );
endinterface

// File: rtl/cart_type_detect.sv
// Tracks the size of a ROM download, waits for the byte matchers to settle,
// then resolves the bankswitch scheme and superchip flag.
module cart_type_detect #(
  parameter int unsigned SETTLE = 2
) (
  input logic             clk,
  input logic             resetn,
  cart_type_detect_if.slave bus
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE - 1);

  localparam logic [3:0] Type2K = 4'd0;
  localparam logic [3:0] Type4K = 4'd1;
  localparam logic [3:0] TypeF8 = 4'd2;
  localparam logic [3:0] TypeE0 = 4'd3;
  localparam logic [3:0] Type3F = 4'd4;
  localparam logic [3:0] TypeFE = 4'd5;
  localparam logic [3:0] TypeFA = 4'd6;
  localparam logic [3:0] TypeE7 = 4'd7;
  localparam logic [3:0] TypeF6 = 4'd8;
  localparam logic [3:0] TypeF4 = 4'd9;

  typedef enum logic [1:0] {StIdle, StLoad, StResolve, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     rom_size_q, rom_size_d;
  logic [3:0]      cart_type_q, cart_type_d;
  logic            sc_q, sc_d;
  logic            type_valid_q, type_valid_d;
  logic            busy_q, busy_d;

  logic            load_start;
  logic            last_settle;
  logic [15:0]     addr_plus1;
  logic [3:0]      dec_type;
  logic            dec_sc;

  // A zero-address byte restarts the download from any state.
  assign load_start  = bus.ena && (bus.addr == 15'd0);
  assign last_settle = (cnt_q == '0);
  assign addr_plus1  = {1'b0, bus.addr} + 16'd1;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rom_size_q   <= '0;
      cart_type_q  <= '0;
      sc_q         <= 1'b0;
      type_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rom_size_q   <= rom_size_d;
      cart_type_q  <= cart_type_d;
      sc_q         <= sc_d;
      type_valid_q <= type_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = StLoad;
    end else begin
      case (state_q)
        StLoad:    if (bus.load_done) state_d = StResolve;
        StResolve: if (last_settle)   state_d = StDone;
        default:   state_d = state_q;
      endcase
    end
  end

  // Scheme decode from the final size and the settled matcher flags.
  always_comb begin
    dec_type = TypeF4;
    if (rom_size_q <= 16'd2048) begin
      dec_type = Type2K;
    end else if (rom_size_q <= 16'd4096) begin
      dec_type = Type4K;
    end else if (rom_size_q <= 16'd8192) begin
      if (bus.match_flags[0])      dec_type = TypeE0;
      else if (bus.match_flags[1]) dec_type = Type3F;
      else if (bus.match_flags[2]) dec_type = TypeFE;
      else                         dec_type = TypeF8;
    end else if (rom_size_q <= 16'd12288) begin
      dec_type = TypeFA;
    end else if (rom_size_q <= 16'd16384) begin
      dec_type = bus.match_flags[3] ? TypeE7 : TypeF6;
    end
    dec_sc = (rom_size_q > 16'd4096) && bus.match_flags[4];
  end

  // Output / datapath next values.
  always_comb begin
    cnt_d        = cnt_q;
    rom_size_d   = rom_size_q;
    cart_type_d  = cart_type_q;
    sc_d         = sc_q;
    type_valid_d = type_valid_q;
    if (load_start) begin
      // Abort leaves the previous cart_type/sc in place, only invalidates them.
      rom_size_d   = 16'd1;
      type_valid_d = 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (bus.ena && (addr_plus1 > rom_size_q)) rom_size_d = addr_plus1;
          if (bus.load_done) cnt_d = CntInit;
        end
        StResolve: begin
          if (last_settle) begin
            cart_type_d  = dec_type;
            sc_d         = dec_sc;
            type_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
    busy_d = (state_d == StLoad) || (state_d == StResolve);
  end

  assign bus.rom_size   = rom_size_q;
  assign bus.cart_type  = cart_type_q;
  assign bus.sc         = sc_q;
  assign bus.type_valid = type_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_cart_type_detect.sv
// Scoreboard bench for cart_type_detect: expected results are queued when a
// download is closed and compared when type_valid rises.
module tb_cart_type_detect;

  localparam int unsigned Settle = 2;

  typedef struct {
    logic [15:0] rom;
    logic [3:0]  ct;
    logic        sc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  cart_type_detect_if bus ();

  cart_type_detect #(.SETTLE(Settle)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_size = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_type(input int size, input logic [4:0] f);
    if (size <= 2048) return 4'd0;
    if (size <= 4096) return 4'd1;
    if (size <= 8192) return f[0] ? 4'd3 : f[1] ? 4'd4 : f[2] ? 4'd5 : 4'd2;
    if (size <= 12288) return 4'd6;
    if (size <= 16384) return f[3] ? 4'd7 : 4'd8;
    return 4'd9;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic track(input int a);
    if (a == 0) exp_size = 1;
    else if (a + 1 > exp_size) exp_size = a + 1;
  endtask

  task automatic send(input int a);
    bus.ena  = 1'b1;
    bus.addr = 15'(a);
    track(a);
    tick();
    bus.ena  = 1'b0;
  endtask

  task automatic load_range(input int last);
    for (int i = 0; i <= last; i++) begin
      bus.ena  = 1'b1;
      bus.addr = 15'(i);
      track(i);
      tick();
    end
    bus.ena = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] f);
    exp_t e;
    e.rom = 16'(exp_size);
    e.ct  = model_type(exp_size, f);
    e.sc  = (exp_size > 4096) && f[4];
    sb_q.push_back(e);
  endtask

  task automatic wait_result(input string tag);
    int   lat = 0;
    exp_t e;
    while (!bus.type_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    if (!bus.type_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_latency"}, lat, Settle);
    check({tag, "_rom_size"}, bus.rom_size, e.rom);
    check({tag, "_cart_type"}, bus.cart_type, e.ct);
    check({tag, "_sc"}, bus.sc, e.sc);
    check({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  // Flags during the load_done cycle may differ from those seen in RESOLVE.
  task automatic resolve(input string tag, input logic [4:0] f_done, input logic [4:0] f_res);
    bus.match_flags = f_done;
    bus.load_done   = 1'b1;
    push_exp(f_res);
    tick();
    bus.load_done   = 1'b0;
    bus.match_flags = f_res;
    wait_result(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rom_size"}, bus.rom_size, 16'd0);
    check({tag, "_cart_type"}, bus.cart_type, 4'd0);
    check({tag, "_sc"}, bus.sc, 1'b0);
    check({tag, "_type_valid"}, bus.type_valid, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    logic tv_seen;
    bus.addr = '0;
    bus.ena = 1'b0;
    bus.load_done = 1'b0;
    bus.match_flags = '0;
    tick();
    tick();
    check_zero("reset");
    resetn = 1'b1;

    // load_done while idle is ignored
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    tick();
    check_zero("idle_ld");

    load_range(4095);
    check("load_busy", bus.busy, 1'b1);
    resolve("size4k", 5'b00000, 5'b00000);

    // restart from DONE
    send(0);
    check("restart_tv", bus.type_valid, 1'b0);
    check("restart_busy", bus.busy, 1'b1);
    check("restart_rom", bus.rom_size, 16'd1);

    load_range(8191);
    resolve("e0_prio", 5'b00011, 5'b00011);
    load_range(16383);
    resolve("e7_sc", 5'b11000, 5'b11000);

    // sparse loads across the decode boundaries
    send(0); send(2047);             resolve("size2k_sc", 5'b10000, 5'b10000);
    send(0); send(3000); send(100);  resolve("no_shrink", 5'b00000, 5'b00000);
    send(0); send(5000);             resolve("f3f", 5'b00010, 5'b00010);
    send(0); send(8191);             resolve("ffe", 5'b00100, 5'b00100);
    send(0); send(6000);             resolve("f8_sc", 5'b00001, 5'b10000);
    send(0); send(12287);            resolve("fa", 5'b00000, 5'b00000);
    send(0); send(12288);            resolve("f6", 5'b00000, 5'b00000);

    // last byte and load_done in the same cycle
    send(0);
    bus.ena = 1'b1;
    bus.addr = 15'h7FFF;
    track(32'h7FFF);
    bus.load_done = 1'b1;
    bus.match_flags = 5'b10000;
    push_exp(5'b10000);
    tick();
    bus.ena = 1'b0;
    bus.load_done = 1'b0;
    wait_result("f4_same");

    // abort during RESOLVE keeps the old cart_type
    send(0); send(2047);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    send(0);
    check("abort_ct", bus.cart_type, 4'd9);
    check("abort_tv", bus.type_valid, 1'b0);
    check("abort_busy", bus.busy, 1'b1);
    tv_seen = 1'b0;
    for (int i = 0; i < Settle + 3; i++) begin
      tick();
      tv_seen |= bus.type_valid;
    end
    check("abort_no_tv", tv_seen, 1'b0);
    resolve("after_abort", 5'b00000, 5'b00000);

    // reset mid-RESOLVE
    send(0); send(4095);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    check_zero("rst_resolve");
    resetn = 1'b1;
    tv_seen = 1'b0;
    for (int i = 0; i < Settle + 4; i++) begin
      tick();
      tv_seen |= bus.type_valid | bus.busy;
    end
    check("rst_no_tv", tv_seen, 1'b0);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cart_type_detect.md
CART_TYPE_DETECT -- requirements
Module: cart_type_detect

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the cycles waited after load_done so upstream match flags can settle.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 The block SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port addr  input  15  ROM load byte address (same stream the byte matchers see).
REQ-005 The block SHALL have port ena  input  1  load byte strobe; addr is valid when high.
REQ-006 The block SHALL have port load_done  input  1  single-cycle pulse marking the end of a ROM download.
REQ-007 The block SHALL have port match_flags  input  5  matcher results: [0] E0, [1] 3F, [2] FE, [3] E7, [4] superchip.
REQ-008 The block SHALL have port rom_size  output  16  highest loaded address + 1, in bytes.
REQ-009 The block SHALL have port cart_type  output  4  resolved bankswitch scheme code.
REQ-010 The block SHALL have port sc  output  1  superchip RAM present.
REQ-011 The block SHALL have port type_valid  output  1  cart_type/sc valid.
REQ-012 The block SHALL have port busy  output  1  high in LOAD or RESOLVE.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, LOAD, RESOLVE, DONE.
REQ-014 The block SHALL enter LOAD from any state on a cycle with ena=1 and addr=0, clearing rom_size to 1 and forcing type_valid=0 on the next cycle.
REQ-015 In LOAD, each ena=1 cycle with addr+1 > rom_size SHALL set rom_size to addr+1; lower addresses SHALL leave rom_size unchanged.
REQ-016 rom_size SHALL use 16-bit arithmetic; addr=0x7FFF SHALL give rom_size=32768 with no wrap.
REQ-017 load_done in LOAD SHALL move the state to RESOLVE; if ena is also high that cycle, the byte SHALL be counted first.
REQ-018 load_done in IDLE, RESOLVE or DONE SHALL be ignored.
REQ-019 RESOLVE SHALL last exactly SETTLE cycles, counted by an internal down-counter; match_flags SHALL be sampled on the last RESOLVE cycle only.
REQ-020 On leaving RESOLVE the block SHALL register cart_type and sc, enter DONE and set type_valid=1 on the same edge.
REQ-021 Decode by rom_size: <=2048 -> 0 (2K); <=4096 -> 1 (4K).
REQ-022 Decode for <=8192: E0 -> 3; else 3F -> 4; else FE -> 5; else 2 (F8). Priority SHALL be E0 > 3F > FE.
REQ-023 Decode for <=12288 -> 6 (FA).
REQ-024 Decode for <=16384: E7 -> 7, else 8 (F6).
REQ-025 Decode for any larger size -> 9 (F4).
REQ-026 sc SHALL equal match_flags[4] when rom_size > 4096, else 0.
REQ-027 DONE SHALL hold all outputs until a new addr=0 load start or reset.
REQ-028 A new addr=0 load start in RESOLVE SHALL abort resolution without updating cart_type.
REQ-029 busy SHALL be registered and reflect the current state.

Reset
REQ-030 With resetn=0 at a clk edge, the block SHALL enter IDLE with rom_size=0, cart_type=0, sc=0, type_valid=0 and busy=0.
REQ-031 Reset SHALL take priority over every other input, including mid-LOAD or mid-RESOLVE.
REQ-032 After reset release, the block SHALL stay in IDLE until an ena=1, addr=0 cycle.

Verification
REQ-033 Load addr 0..4095 with flags=0, then load_done -> after SETTLE+1 cycles: rom_size=4096, cart_type=1, sc=0, type_valid=1.
REQ-034 Load addr 0..8191 with flags=5'b00011, then load_done -> cart_type=3 (E0 wins priority), rom_size=8192.
REQ-035 Load addr 0..16383 with flags=5'b11000, then load_done -> cart_type=7, sc=1.
REQ-036 Addr=0x7FFF with ena in the same cycle as load_done -> rom_size=32768, cart_type=9.
REQ-037 In DONE, an ena=1, addr=0 cycle -> next cycle type_valid=0, busy=1, rom_size=1; a load_done pulse in IDLE -> no state change.
REQ-038 resetn=0 mid-RESOLVE -> IDLE with all outputs zero, and no type_valid pulse afterwards.
